// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp: multi-read-port register file with x0 hardwired, registered reads and a hardware clear sequencer (RF_BYPASS_EN selects write-first reads)
module rv_regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic              we,
  input  logic [AW-1:0]     rd,
  input  logic [XLEN-1:0]   data_in,
  output logic              ready,
  output logic              clr_busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
  localparam logic [AW-1:0] LAST   = AW'(NREG - 1);
  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [XLEN-1:0] mem [NREG];
  logic [NRD*XLEN-1:0] rd_val;
  logic wr_ok;
  assign wr_ok = state == RUN && we && rd != '0 && {1'b0, rd} < NREG_W;
  assign ready = state == RUN;
  assign clr_busy = state == CLEAR;
  always_comb begin
    state_n = (state == CLEAR && cnt == LAST) ? RUN : state;
    cnt_n = (state == CLEAR && cnt != LAST) ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= AW'(1);
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // Storage has no reset so it can map onto RAM; the sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_ok) mem[rd] <= data_in;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic byp;
    assign a = rs_addr[k*AW +: AW];
`ifdef RF_BYPASS_EN
    assign byp = wr_ok && rd == a;
`else
    assign byp = 1'b0;
`endif
    assign rd_val[k*XLEN +: XLEN] = (a == '0 || {1'b0, a} >= NREG_W) ? '0 : byp ? data_in : mem[a];
  end
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) rs_data <= '0;
    else rs_data <= rd_val;
  end
endmodule

// File: tb/tb_rv_regfile_mp.sv
// tb_rv_regfile_mp: directed checks of the default and a wide 4-port build of rv_regfile_mp.
module tb_rv_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic we;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic ready, clr_busy;
  logic [19:0]  p_addr;
  logic [255:0] p_data;
  logic p_we;
  logic [4:0]  p_rd;
  logic [63:0] p_din;
  logic p_ready, p_busy;
  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  rv_regfile_mp u_dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .we(we), .rd(rd),
    .data_in(data_in), .ready(ready), .clr_busy(clr_busy)
  );

  rv_regfile_mp #(.XLEN(64), .NREG(20), .NRD(4), .AW(5)) u_p (
    .clk(clk), .rst(rst), .rs_addr(p_addr), .rs_data(p_data), .we(p_we), .rd(p_rd),
    .data_in(p_din), .ready(p_ready), .clr_busy(p_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic busy_len();
    n = 0;
    for (int i = 0; i < 100 && clr_busy; i++) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1; rs_addr = '0; we = 1'b0; rd = '0; data_in = '0;
    p_addr = '0; p_we = 1'b0; p_rd = '0; p_din = '0;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_data", rs_data, 64'h0);
    chk("rst_ready", {63'h0, ready}, 64'h0);
    chk("rst_busy", {63'h0, clr_busy}, 64'h1);
    chk("p_rst_busy", {63'h0, p_busy}, 64'h1);
    rst = 1'b0;
    busy_len();
    chk("clear_len", 64'(n), 64'd31);
    chk("ready_after_clear", {63'h0, ready}, 64'h1);
    for (int a = 0; a < 32; a += 2) begin
      rs_addr = {5'(a + 1), 5'(a)};
      cyc();
      chk($sformatf("clr_rd%0d", a), rs_data, 64'h0);
    end
    we = 1'b1; rd = 5'd5; data_in = 32'hDEADBEEF;
    cyc();
    we = 1'b0; rs_addr = {5'd0, 5'd5};
    cyc();
    chk("rd5_p0", {32'h0, rs_data[31:0]}, 64'hDEADBEEF);
    we = 1'b1; rd = 5'd31; data_in = 32'hCAFEF00D;
    cyc();
    we = 1'b0; rs_addr = {5'd31, 5'd5};
    cyc();
    chk("rd31_rd5", rs_data, 64'hCAFEF00D_DEADBEEF);
    we = 1'b1; rd = 5'd0; data_in = 32'hFFFFFFFF;
    cyc();
    we = 1'b0; rs_addr = '0;
    cyc();
    chk("x0_both", rs_data, 64'h0);
    we = 1'b1; rd = 5'd7; data_in = 32'h11;
    cyc();
    data_in = 32'h22; rs_addr = {5'd7, 5'd7};
    cyc();
    we = 1'b0;
`ifdef RF_BYPASS_EN
    chk("collide", rs_data, 64'h00000022_00000022);
`else
    chk("collide", rs_data, 64'h00000011_00000011);
`endif
    cyc();
    chk("after_collide", rs_data, 64'h00000022_00000022);
    we = 1'b1; rd = 5'd3; data_in = 32'hA5;
    cyc();
    we = 1'b0; rs_addr = {5'd3, 5'd7};
    cyc();
    chk("rd3", rs_data, 64'h000000A5_00000022);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("mid_clear_busy", {63'h0, clr_busy}, 64'h1);
    chk("clear_reads_zero", rs_data, 64'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0; we = 1'b1; rd = 5'd4; data_in = 32'h55;
    busy_len();
    we = 1'b0;
    chk("reclear_len", 64'(n), 64'd31);
    rs_addr = {5'd4, 5'd3};
    cyc();
    chk("rd4_rd3_cleared", rs_data, 64'h0);
    chk("p_ready", {63'h0, p_ready}, 64'h1);
    p_we = 1'b1; p_rd = 5'd19; p_din = 64'h0123456789ABCDEF;
    cyc();
    p_we = 1'b0; p_addr = {4{5'd19}};
    cyc();
    for (int k = 0; k < 4; k++)
      chk($sformatf("p_rd19_port%0d", k), p_data[k*64 +: 64], 64'h0123456789ABCDEF);
    p_we = 1'b1; p_rd = 5'd25; p_din = 64'hFFFFFFFFFFFFFFFF;
    cyc();
    p_we = 1'b0; p_addr = {5'd25, 5'd0, 5'd19, 5'd25};
    cyc();
    chk("p_rd25_port0", p_data[63:0], 64'h0);
    chk("p_rd19_port1", p_data[127:64], 64'h0123456789ABCDEF);
    chk("p_rd0_port2", p_data[191:128], 64'h0);
    chk("p_rd25_port3", p_data[255:192], 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rv_regfile_mp.md
Name: rv_regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RV32I core. Successor to the single-write, dual-read register file.
- Adds configurable data width, register count and read-port count.
- Adds a synchronous reset that starts a hardware clear sequencer, plus a ready flag for the pipeline.
- Register 0 is hardwired to zero; read data is registered (one-cycle latency).

Parameters:
- XLEN, 32, data width of each register in bits.
- NREG, 32, number of architectural registers (2..64, need not be a power of two).
- NRD, 2, number of independent read ports (1..4).
- AW, 5, address width per port; must satisfy 2**AW >= NREG.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rs_addr  input  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- rs_data  output  NRD*XLEN  registered read data, port k at bits [k*XLEN +: XLEN]
- we  input  1  write enable
- rd  input  AW  write address
- data_in  input  XLEN  write data
- ready  output  1  high when clear sequence done and writes are accepted
- clr_busy  output  1  high while clear sequencer is running

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- States: CLEAR, RUN. rst=1 at a rising edge forces CLEAR with clear counter = 1, regardless of current state (reset mid-clear restarts the sequence).
- Reset values:
  - rs_data = 0, ready = 0, clr_busy = 1 (from the cycle after rst is sampled high).
  - Array contents are not reset directly; the sequencer zeroes them.
- CLEAR:
  - Each cycle, write 0 to register[counter], then counter += 1.
  - When counter == NREG-1 is written, next state is RUN, ready = 1, clr_busy = 0.
  - Clear duration is NREG-1 cycles after rst deasserts.
  - External we is ignored. All rs_data outputs register 0.
- RUN:
  - Writes: if we=1, rd != 0 and rd < NREG, then register[rd] <= data_in at the edge. Writes to rd=0 or rd >= NREG are dropped silently.
  - Reads: each port k independently captures register[rs_addr_k] into rs_data_k at every edge (latency 1, no enable). rs_addr_k == 0 or >= NREG yields 0.
  - Multiple ports may read the same address in the same cycle; all return identical data.
  - Same-cycle write and read of the same address: the value returned is set by RF_BYPASS_EN (see Optional Feature).
- Register 0 always reads 0, including under bypass.
- Arithmetic: clear counter is AW bits wide. Address comparisons are unsigned. No wrap-around beyond NREG-1.
- No X propagation: every output is driven to a defined value in every state.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-first. If we=1 in RUN with valid nonzero rd equal to rs_addr_k, rs_data_k captures data_in in that cycle. This lets writeback and decode share a cycle without a hazard stall.
- Undefined: read-before-write. rs_data_k captures the old array contents, and the new value is visible from the next read cycle.
- The macro has no effect in CLEAR or for address 0.

Test Plan:
- Reset and clear:
  - Stimulus: rst=1 for 2 cycles, release.
  - Required: clr_busy=1 and ready=0 for exactly 31 cycles (NREG=32), then ready=1. Reading all addresses 0..31 returns 0x00000000.
- Write/read latency:
  - Stimulus: we=1, rd=5, data_in=0xDEADBEEF; next cycle rs_addr port0=5.
  - Required: rs_data port0 = 0xDEADBEEF one edge later.
- x0 protection:
  - Stimulus: we=1, rd=0, data_in=0xFFFFFFFF; then read address 0 on all ports.
  - Required: all ports return 0.
- Same-cycle collision:
  - Stimulus: register 7 holds 0x11; in one cycle set we=1, rd=7, data_in=0x22 and rs_addr port1=7.
  - Required: rs_data port1 = 0x22 with RF_BYPASS_EN defined, 0x11 without it. The following cycle returns 0x22 in both builds.
- Reset mid-operation:
  - Stimulus: write 0xA5 to register 3; assert rst 10 cycles into a clear; attempt we=1, rd=4 during CLEAR.
  - Required: the clear restarts, full 31-cycle busy window. Registers 3 and 4 read 0 after ready.
- Parametrised build:
  - Stimulus: NREG=20, NRD=4, XLEN=64. Write 0x0123456789ABCDEF to register 19; read it on all 4 ports; also read address 25.
  - Required: all 4 ports return the 64-bit value. Address 25 returns 0. A write to address 25 is dropped.
